mismatch_scoreboard: RTL and testbench

MISMATCH_SCOREBOARD -- requirements
Module: mismatch_scoreboard

---
 rtl/tb_check_pkg.sv | 20 ++
 rtl/mismatch_scoreboard_if.sv | 11 +
 rtl/sat_counter.sv | 22 ++
 rtl/mismatch_scoreboard.sv | 136 +++++++++++++
 tb/tb_mismatch_scoreboard.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tb_check_pkg.sv
// Shared definitions for the mismatch scoreboard: run-state encoding and a
// constant helper giving the saturation ceiling of a counter of a given width.
package tb_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } check_state_t;

    localparam int SAT_MAX_W = 64;

    function automatic logic [SAT_MAX_W-1:0] sat_all_ones(input int width);
        if (width >= SAT_MAX_W) begin
            return '1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/mismatch_scoreboard_if.sv
// Sample bus carrying the reference and DUT values to be compared each cycle.
interface mismatch_scoreboard_if #(
    parameter int WIDTH = 1
);
    logic             sample_valid;
    logic [WIDTH-1:0] ref_val;
    logic [WIDTH-1:0] dut_val;

    modport master (output sample_valid, ref_val, dut_val);
    modport slave  (input  sample_valid, ref_val, dut_val);
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    import tb_check_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_all_ones(CNT_W));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/mismatch_scoreboard.sv
// Compares a reference stream against a DUT stream during a start/stop bounded
// run and keeps a registered report: sample and error counts, first error, bit mask.
module mismatch_scoreboard #(
    parameter int WIDTH     = 1,
    parameter int CNT_W     = 32,
    parameter int N_SAMPLES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    mismatch_scoreboard_if.slave smp,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     samples,
    output logic [CNT_W-1:0]     errors,
    output logic [CNT_W-1:0]     first_err_cycle,
    output logic                 first_err_valid,
    output logic [WIDTH-1:0]     err_mask
);
    import tb_check_pkg::*;

    check_state_t     state, state_next;
    logic             enter_run;
    logic             in_run;
    logic             count_sample;
    logic             count_error;
    logic             hits_target;
    logic             errors_zero_next;
    logic [WIDTH-1:0] diff;
    logic [CNT_W-1:0] cycle_idx;

    assign diff   = smp.ref_val ^ smp.dut_val;
    assign in_run = (state == RUN);

    // Auto-stop fires on the sample that takes the count up to N_SAMPLES.
    generate
        if (N_SAMPLES > 0) begin : g_auto_stop
            localparam logic [CNT_W-1:0] LAST_BEFORE = CNT_W'(N_SAMPLES - 1);
            assign hits_target = (samples == LAST_BEFORE);
        end else begin : g_no_auto_stop
            assign hits_target = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        enter_run    = 1'b0;
        count_sample = 1'b0;
        count_error  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    enter_run  = 1'b1;
                end
            end
            RUN: begin
                count_sample = smp.sample_valid;
                count_error  = smp.sample_valid && (|diff);
                if (stop || (count_sample && hits_target)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    enter_run  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_samples (
        .clk   (clk),
        .reset (reset),
        .clr   (enter_run),
        .inc   (count_sample),
        .count (samples)
    );

    sat_counter #(.CNT_W(CNT_W)) u_errors (
        .clk   (clk),
        .reset (reset),
        .clr   (enter_run),
        .inc   (count_error),
        .count (errors)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk   (clk),
        .reset (reset),
        .clr   (enter_run),
        .inc   (in_run),
        .count (cycle_idx)
    );

    // Status flags are registered from the next state so they line up with the counters.
    assign errors_zero_next = enter_run || ((errors == '0) && !count_error);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            first_err_cycle <= '0;
            first_err_valid <= 1'b0;
            err_mask        <= '0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            pass <= (state_next == DONE) && errors_zero_next;
            if (enter_run) begin
                first_err_cycle <= '0;
                first_err_valid <= 1'b0;
                err_mask        <= '0;
            end else if (count_error) begin
                err_mask <= err_mask | diff;
                if (!first_err_valid) begin
                    first_err_cycle <= cycle_idx;
                    first_err_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mismatch_scoreboard.sv
// Self-checking bench: four scoreboard instances (1-bit, 8-bit, auto-stop, 3-bit counters)
// driven from one stimulus stream; a vector table feeds an expected-value queue.
module tb_mismatch_scoreboard;

    logic clk;
    logic reset;
    logic start;
    logic stop;

    int checks   = 0;
    int failures = 0;

    mismatch_scoreboard_if #(.WIDTH(1)) if1 ();
    mismatch_scoreboard_if #(.WIDTH(8)) if8 ();

    logic        w1_busy, w1_done, w1_pass, w1_fev;
    logic [31:0] w1_samples, w1_errors, w1_fec;
    logic [0:0]  w1_mask;

    logic        w8_busy, w8_done, w8_pass, w8_fev;
    logic [31:0] w8_samples, w8_errors, w8_fec;
    logic [7:0]  w8_mask;

    logic        au_busy, au_done, au_pass, au_fev;
    logic [31:0] au_samples, au_errors, au_fec;
    logic [0:0]  au_mask;

    logic        st_busy, st_done, st_pass, st_fev;
    logic [2:0]  st_samples, st_errors, st_fec;
    logic [0:0]  st_mask;

    mismatch_scoreboard #(.WIDTH(1)) u_w1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .smp(if1),
        .busy(w1_busy), .done(w1_done), .pass(w1_pass), .samples(w1_samples),
        .errors(w1_errors), .first_err_cycle(w1_fec), .first_err_valid(w1_fev),
        .err_mask(w1_mask)
    );

    mismatch_scoreboard #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .smp(if8),
        .busy(w8_busy), .done(w8_done), .pass(w8_pass), .samples(w8_samples),
        .errors(w8_errors), .first_err_cycle(w8_fec), .first_err_valid(w8_fev),
        .err_mask(w8_mask)
    );

    mismatch_scoreboard #(.WIDTH(1), .N_SAMPLES(5)) u_auto (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .smp(if1),
        .busy(au_busy), .done(au_done), .pass(au_pass), .samples(au_samples),
        .errors(au_errors), .first_err_cycle(au_fec), .first_err_valid(au_fev),
        .err_mask(au_mask)
    );

    mismatch_scoreboard #(.WIDTH(1), .CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .smp(if1),
        .busy(st_busy), .done(st_done), .pass(st_pass), .samples(st_samples),
        .errors(st_errors), .first_err_cycle(st_fec), .first_err_valid(st_fev),
        .err_mask(st_mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic        valid;
        logic        stp;
        logic [7:0]  r;
        logic [7:0]  d;
        logic [31:0] exp_samples;
        logic [31:0] exp_errors;
        logic [7:0]  exp_mask;
        logic        exp_busy;
    } vec_t;

    typedef struct {
        logic [31:0] samples;
        logic [31:0] errors;
        logic [7:0]  mask;
        logic        busy;
    } exp_t;

    vec_t vecs[10];
    exp_t sbq[$];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic st, input logic sp, input logic v,
                                 input logic [7:0] r, input logic [7:0] d);
        start            = st;
        stop             = sp;
        if8.sample_valid = v;
        if8.ref_val      = r;
        if8.dut_val      = d;
        if1.sample_valid = v;
        if1.ref_val      = r[0];
        if1.dut_val      = d[0];
        @(posedge clk);
        #1;
        start            = 1'b0;
        stop             = 1'b0;
        if8.sample_valid = 1'b0;
        if1.sample_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        exp_t        e;
        logic [7:0]  x;

        vecs[0] = '{1'b1, 1'b0, 8'h3C, 8'h3C, 32'd1, 32'd0, 8'h00, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 8'hFF, 8'h00, 32'd1, 32'd0, 8'h00, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 8'hA5, 8'hA4, 32'd2, 32'd1, 8'h01, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 8'h00, 32'd3, 32'd1, 8'h01, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 8'hF0, 8'h70, 32'd4, 32'd2, 8'h81, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 8'h12, 8'h16, 32'd5, 32'd3, 8'h85, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 8'h55, 8'h55, 32'd6, 32'd3, 8'h85, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 8'hFF, 32'd6, 32'd3, 8'h85, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 8'h0F, 8'h0E, 32'd7, 32'd4, 8'h85, 1'b1};
        vecs[9] = '{1'b1, 1'b1, 8'h40, 8'h00, 32'd8, 32'd5, 8'hC5, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        if1.sample_valid = 1'b0; if1.ref_val = '0; if1.dut_val = '0;
        if8.sample_valid = 1'b0; if8.ref_val = '0; if8.dut_val = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 8'h00);
        checkOutput("reset_busy", w8_busy, 0);
        checkOutput("reset_done", w8_done, 0);
        checkOutput("reset_pass", w8_pass, 0);
        checkOutput("reset_samples", w8_samples, 0);
        checkOutput("reset_errors", w8_errors, 0);
        checkOutput("reset_fec", w8_fec, 0);
        checkOutput("reset_fev", w8_fev, 0);
        checkOutput("reset_mask", w8_mask, 0);
        reset = 1'b0;

        $display("[TB] table run with mixed matches and mismatches");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("start_busy", w8_busy, 1);
        for (int i = 0; i < 10; i++) begin
            sbq.push_back('{vecs[i].exp_samples, vecs[i].exp_errors, vecs[i].exp_mask, vecs[i].exp_busy});
            applyStimulus(1'b0, vecs[i].stp, vecs[i].valid, vecs[i].r, vecs[i].d);
            e = sbq.pop_front();
            checkOutput($sformatf("vec%0d_samples", i), w8_samples, e.samples);
            checkOutput($sformatf("vec%0d_errors", i), w8_errors, e.errors);
            checkOutput($sformatf("vec%0d_mask", i), w8_mask, e.mask);
            checkOutput($sformatf("vec%0d_busy", i), w8_busy, e.busy);
        end
        checkOutput("tbl_done", w8_done, 1);
        checkOutput("tbl_pass", w8_pass, 0);
        checkOutput("tbl_fev", w8_fev, 1);
        checkOutput("tbl_fec", w8_fec, 2);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 8'h00);
        end
        checkOutput("hold_samples", w8_samples, 8);
        checkOutput("hold_errors", w8_errors, 5);
        checkOutput("hold_mask", w8_mask, 8'hC5);
        checkOutput("hold_done", w8_done, 1);

        $display("[TB] restart from DONE");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("restart_busy", w8_busy, 1);
        checkOutput("restart_done", w8_done, 0);
        checkOutput("restart_samples", w8_samples, 0);
        checkOutput("restart_errors", w8_errors, 0);
        checkOutput("restart_mask", w8_mask, 0);
        checkOutput("restart_fev", w8_fev, 0);
        checkOutput("restart_fec", w8_fec, 0);

        $display("[TB] all-match run with auto-stop observation");
        for (int i = 1; i <= 10; i++) begin
            x = 8'($urandom);
            applyStimulus(1'b0, 1'b0, 1'b1, x, x);
            checkOutput($sformatf("auto%0d_samples", i), au_samples, imin(i, 5));
            checkOutput($sformatf("auto%0d_done", i), au_done, (i >= 5) ? 1 : 0);
            checkOutput($sformatf("auto%0d_busy", i), au_busy, (i < 5) ? 1 : 0);
            checkOutput($sformatf("sat%0d_samples", i), st_samples, imin(i, 7));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        checkOutput("match_done", w8_done, 1);
        checkOutput("match_samples", w8_samples, 10);
        checkOutput("match_errors", w8_errors, 0);
        checkOutput("match_pass", w8_pass, 1);
        checkOutput("match_fev", w8_fev, 0);
        checkOutput("match_w1_pass", w1_pass, 1);
        checkOutput("match_w1_samples", w1_samples, 10);
        checkOutput("match_auto_samples", au_samples, 5);

        $display("[TB] single mismatch at RUN cycle 4, start ignored mid-run");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 8; k++) begin
            x = 8'($urandom);
            applyStimulus((k == 6) ? 1'b1 : 1'b0, 1'b0, 1'b1, x, x ^ ((k == 4) ? 8'h01 : 8'h00));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        checkOutput("single_samples", w1_samples, 8);
        checkOutput("single_errors", w1_errors, 1);
        checkOutput("single_fec", w1_fec, 4);
        checkOutput("single_fev", w1_fev, 1);
        checkOutput("single_mask", w1_mask, 1);
        checkOutput("single_pass", w1_pass, 0);
        checkOutput("single_done", w1_done, 1);
        checkOutput("single_w8_mask", w8_mask, 8'h01);

        $display("[TB] reset mid-run and simultaneous start/stop");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h21, 8'h20);
        end
        checkOutput("prereset_errors", w8_errors, 3);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h21, 8'h20);
        reset = 1'b0;
        checkOutput("midreset_busy", w8_busy, 0);
        checkOutput("midreset_done", w8_done, 0);
        checkOutput("midreset_samples", w8_samples, 0);
        checkOutput("midreset_errors", w8_errors, 0);
        checkOutput("midreset_mask", w8_mask, 0);
        checkOutput("midreset_fev", w8_fev, 0);
        checkOutput("midreset_fec", w8_fec, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        checkOutput("idle_startstop_busy", w8_busy, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        checkOutput("run_startstop_done", w8_done, 1);
        checkOutput("run_startstop_busy", w8_busy, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        checkOutput("done_startstop_busy", w8_busy, 1);
        checkOutput("done_startstop_done", w8_done, 0);

        $display("[TB] saturation with 3-bit counters");
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 8'h00);
            checkOutput($sformatf("sat%0d_samples", i), st_samples, imin(i, 7));
            checkOutput($sformatf("sat%0d_errors", i), st_errors, imin(i, 7));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        checkOutput("sat_done", st_done, 1);
        checkOutput("sat_samples", st_samples, 7);
        checkOutput("sat_errors", st_errors, 7);
        checkOutput("sat_pass", st_pass, 0);
        checkOutput("sat_fec", st_fec, 0);
        checkOutput("sat_w8_errors", w8_errors, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
